// File: rtl/ddmtd_pkg.sv
// Shared definitions for the DDMTD lock sequencer: state codes and gain limits.
package ddmtd_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned GAIN_W  = 2;
    localparam int unsigned LOL_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_TRACK   = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [GAIN_W-1:0] GAIN_MAX = 2'b11;
    localparam logic [GAIN_W-1:0] GAIN_MIN = 2'b00;

endpackage

// File: rtl/ddmtd_abs_cmp.sv
// Saturating magnitude of the signed phase error plus the three threshold qualifiers.
// Ports:
//   phase_err  in   ERR_W  signed (two's complement) phase error
//   acq_ok     out  1      |err| <= ACQ_THR
//   lock_ok    out  1      |err| <= LOCK_THR
//   strike     out  1      |err| >  UNLOCK_THR
module ddmtd_abs_cmp #(
    parameter int unsigned ERR_W      = 16,
    parameter int unsigned ACQ_THR    = 1024,
    parameter int unsigned LOCK_THR   = 64,
    parameter int unsigned UNLOCK_THR = 256
) (
    input  logic [ERR_W-1:0] phase_err,
    output logic             acq_ok,
    output logic             lock_ok,
    output logic             strike
);

    localparam logic [ERR_W-1:0] MOST_NEG = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [ERR_W-1:0] MOST_POS = {1'b0, {(ERR_W-1){1'b1}}};

    logic [ERR_W-1:0] abs_err;

    // The most negative code has no positive twin; clamp it to the largest positive value.
    always_comb begin
        if (phase_err == MOST_NEG) begin
            abs_err = MOST_POS;
        end else if (phase_err[ERR_W-1]) begin
            abs_err = (~phase_err) + ERR_W'(1);
        end else begin
            abs_err = phase_err;
        end
        acq_ok  = (32'(abs_err) <= ACQ_THR);
        lock_ok = (32'(abs_err) <= LOCK_THR);
        strike  = (32'(abs_err) >  UNLOCK_THR);
    end

endmodule

// File: rtl/ddmtd_lock_sequencer.sv
// Acquisition/lock controller for the DDMTD helper-PLL: sequences integrator clear,
// P/I gain selection, lock detection, loss-of-lock recovery and acquisition timeout.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena                 low freezes all state and outputs
//   start               level run request; low returns to IDLE
//   auto_en             1: FSM selects gains, 0: kp_user/ki_user passed through
//   kp_user, ki_user    user gains
//   phase_valid         one-cycle strobe qualifying phase_err
//   phase_err           signed phase error
//   kp_sel, ki_sel      gains to loop filter
//   int_clear           integrator clear
//   locked, fault       status
//   state_o             current state code
//   lol_count           saturating loss-of-lock event count
module ddmtd_lock_sequencer
    import ddmtd_pkg::*;
#(
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned ACQ_THR     = 1024,
    parameter int unsigned LOCK_THR    = 64,
    parameter int unsigned UNLOCK_THR  = 256,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned UNLOCK_CNT  = 4,
    parameter int unsigned CLEAR_CYC   = 8,
    parameter int unsigned ACQ_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             auto_en,
    input  logic [1:0]       kp_user,
    input  logic [1:0]       ki_user,
    input  logic             phase_valid,
    input  logic [ERR_W-1:0] phase_err,
    output logic [1:0]       kp_sel,
    output logic [1:0]       ki_sel,
    output logic             int_clear,
    output logic             locked,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [7:0]       lol_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned STK_W = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned CLR_W = $clog2(CLEAR_CYC + 1);
    localparam int unsigned TMO_W = $clog2(ACQ_TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [RUN_W-1:0]   run_cnt, run_nxt;
    logic [STK_W-1:0]   strike_cnt, strike_nxt;
    logic [CLR_W-1:0]   clr_cnt, clr_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
    logic [LOL_W-1:0]   lol_cnt, lol_nxt;
    logic [GAIN_W-1:0]  kp_nxt, ki_nxt;
    logic               clear_nxt, locked_nxt, fault_nxt;
    logic               acq_ok, lock_ok, strike_hit;

    ddmtd_abs_cmp #(
        .ERR_W      (ERR_W),
        .ACQ_THR    (ACQ_THR),
        .LOCK_THR   (LOCK_THR),
        .UNLOCK_THR (UNLOCK_THR)
    ) u_abs_cmp (
        .phase_err (phase_err),
        .acq_ok    (acq_ok),
        .lock_ok   (lock_ok),
        .strike    (strike_hit)
    );

    // State, counters and outputs; everything holds while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            run_cnt    <= '0;
            strike_cnt <= '0;
            clr_cnt    <= '0;
            tmo_cnt    <= '0;
            lol_cnt    <= '0;
            kp_sel     <= GAIN_MIN;
            ki_sel     <= GAIN_MIN;
            int_clear  <= 1'b1;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else if (ena) begin
            state      <= state_nxt;
            run_cnt    <= run_nxt;
            strike_cnt <= strike_nxt;
            clr_cnt    <= clr_nxt;
            tmo_cnt    <= tmo_nxt;
            lol_cnt    <= lol_nxt;
            kp_sel     <= kp_nxt;
            ki_sel     <= ki_nxt;
            int_clear  <= clear_nxt;
            locked     <= locked_nxt;
            fault      <= fault_nxt;
        end
    end

    // Next-state, counter update and Moore output decode from the next state.
    always_comb begin
        state_nxt  = state;
        run_nxt    = run_cnt;
        strike_nxt = strike_cnt;
        clr_nxt    = clr_cnt;
        tmo_nxt    = tmo_cnt;
        lol_nxt    = lol_cnt;
        kp_nxt     = GAIN_MIN;
        ki_nxt     = GAIN_MIN;
        clear_nxt  = 1'b1;
        locked_nxt = 1'b0;
        fault_nxt  = 1'b0;

        if (!start) begin
            // Dropping start wins over any pending measurement.
            state_nxt  = ST_IDLE;
            run_nxt    = '0;
            strike_nxt = '0;
            clr_nxt    = '0;
            tmo_nxt    = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nxt = ST_CLEAR;
                    clr_nxt   = '0;
                end
                ST_CLEAR: begin
                    run_nxt    = '0;
                    strike_nxt = '0;
                    tmo_nxt    = '0;
                    if (clr_cnt >= CLR_W'(CLEAR_CYC - 1)) begin
                        state_nxt = ST_ACQUIRE;
                        clr_nxt   = '0;
                    end else begin
                        clr_nxt = clr_cnt + CLR_W'(1);
                    end
                end
                ST_ACQUIRE, ST_TRACK: begin
                    if (phase_valid) begin
                        // Timeout budget spans ACQUIRE<->TRACK bounces and beats threshold moves.
                        if (tmo_cnt >= TMO_W'(ACQ_TIMEOUT - 1)) begin
                            state_nxt = ST_FAULT;
                            run_nxt   = '0;
                        end else begin
                            tmo_nxt = tmo_cnt + TMO_W'(1);
                            if (state == ST_ACQUIRE) begin
                                if (!acq_ok) begin
                                    run_nxt = '0;
                                end else if (run_cnt >= RUN_W'(LOCK_CNT - 1)) begin
                                    state_nxt = ST_TRACK;
                                    run_nxt   = '0;
                                end else begin
                                    run_nxt = run_cnt + RUN_W'(1);
                                end
                            end else begin
                                if (!acq_ok) begin
                                    state_nxt = ST_ACQUIRE;
                                    run_nxt   = '0;
                                end else if (!lock_ok) begin
                                    run_nxt = '0;
                                end else if (run_cnt >= RUN_W'(LOCK_CNT - 1)) begin
                                    state_nxt  = ST_LOCKED;
                                    run_nxt    = '0;
                                    strike_nxt = '0;
                                end else begin
                                    run_nxt = run_cnt + RUN_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (phase_valid) begin
                        if (!strike_hit) begin
                            strike_nxt = '0;
                        end else if (strike_cnt >= STK_W'(UNLOCK_CNT - 1)) begin
                            state_nxt  = ST_ACQUIRE;
                            strike_nxt = '0;
                            run_nxt    = '0;
                            tmo_nxt    = '0;
                            if (lol_cnt != {LOL_W{1'b1}}) begin
                                lol_nxt = lol_cnt + LOL_W'(1);
                            end
                        end else begin
                            strike_nxt = strike_cnt + STK_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        case (state_nxt)
            ST_ACQUIRE: begin
                kp_nxt    = GAIN_MAX;
                ki_nxt    = GAIN_MAX;
                clear_nxt = 1'b0;
            end
            ST_TRACK: begin
                kp_nxt    = kp_user;
                ki_nxt    = ki_user;
                clear_nxt = 1'b0;
            end
            ST_LOCKED: begin
                kp_nxt     = kp_user;
                ki_nxt     = ki_user;
                clear_nxt  = 1'b0;
                locked_nxt = 1'b1;
            end
            ST_FAULT: begin
                fault_nxt = 1'b1;
            end
            default: begin
                clear_nxt = 1'b1;
            end
        endcase

        if (!auto_en) begin
            kp_nxt = kp_user;
            ki_nxt = ki_user;
        end
    end

    assign state_o   = state;
    assign lol_count = lol_cnt;

endmodule

// File: tb/tb_ddmtd_lock_sequencer.sv
// Self-checking bench for ddmtd_lock_sequencer: directed scenarios plus a random phase,
// all compared cycle by cycle against a behavioural reference model.
module tb_ddmtd_lock_sequencer;

    localparam int ACQ_THR     = 1024;
    localparam int LOCK_THR    = 64;
    localparam int UNLOCK_THR  = 256;
    localparam int LOCK_CNT    = 16;
    localparam int UNLOCK_CNT  = 4;
    localparam int CLEAR_CYC   = 8;
    localparam int ACQ_TIMEOUT = 4096;

    localparam int S_IDLE = 0, S_CLEAR = 1, S_ACQ = 2, S_TRACK = 3, S_LOCKED = 4, S_FAULT = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b1;
    logic [1:0]  kp_user = 2'b01;
    logic [1:0]  ki_user = 2'b10;
    logic        phase_valid = 1'b0;
    logic [15:0] phase_err = 16'd0;
    logic [1:0]  kp_sel, ki_sel;
    logic        int_clear, locked, fault;
    logic [2:0]  state_o;
    logic [7:0]  lol_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int m_st, m_run, m_strike, m_budget, m_clear_left, m_lol;
    int e_kp, e_ki, e_clr, e_lock, e_fault;

    ddmtd_lock_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .start       (start),
        .auto_en     (auto_en),
        .kp_user     (kp_user),
        .ki_user     (ki_user),
        .phase_valid (phase_valid),
        .phase_err   (phase_err),
        .kp_sel      (kp_sel),
        .ki_sel      (ki_sel),
        .int_clear   (int_clear),
        .locked      (locked),
        .fault       (fault),
        .state_o     (state_o),
        .lol_count   (lol_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int abs_sat(input logic [15:0] e);
        int v;
        v = int'($signed(e));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_run = 0; m_strike = 0; m_budget = ACQ_TIMEOUT;
        m_clear_left = 0; m_lol = 0;
        e_kp = 0; e_ki = 0; e_clr = 1; e_lock = 0; e_fault = 0;
    endtask

    // One clock edge worth of behaviour, using the inputs present at the edge.
    task automatic model_step();
        int a;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ena) return;
        a = abs_sat(phase_err);
        if (!start) begin
            m_st = S_IDLE; m_run = 0; m_strike = 0;
        end else begin
            case (m_st)
                S_IDLE: begin
                    m_st = S_CLEAR;
                    m_clear_left = CLEAR_CYC;
                end
                S_CLEAR: begin
                    m_clear_left--;
                    if (m_clear_left == 0) begin
                        m_st = S_ACQ; m_run = 0; m_strike = 0; m_budget = ACQ_TIMEOUT;
                    end
                end
                S_ACQ, S_TRACK: if (phase_valid) begin
                    m_budget--;
                    if (m_budget == 0) m_st = S_FAULT;
                    else if (m_st == S_ACQ) begin
                        if (a <= ACQ_THR) begin
                            m_run++;
                            if (m_run == LOCK_CNT) begin m_st = S_TRACK; m_run = 0; end
                        end else m_run = 0;
                    end else if (a > ACQ_THR) begin
                        m_st = S_ACQ; m_run = 0;
                    end else if (a <= LOCK_THR) begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin m_st = S_LOCKED; m_strike = 0; end
                    end else m_run = 0;
                end
                S_LOCKED: if (phase_valid) begin
                    if (a > UNLOCK_THR) begin
                        m_strike++;
                        if (m_strike == UNLOCK_CNT) begin
                            m_st = S_ACQ; m_run = 0; m_strike = 0; m_budget = ACQ_TIMEOUT;
                            m_lol = (m_lol < 255) ? m_lol + 1 : 255;
                        end
                    end else m_strike = 0;
                end
                default: ;
            endcase
        end
        e_clr   = (m_st == S_ACQ || m_st == S_TRACK || m_st == S_LOCKED) ? 0 : 1;
        e_lock  = (m_st == S_LOCKED) ? 1 : 0;
        e_fault = (m_st == S_FAULT) ? 1 : 0;
        if (!auto_en || m_st == S_TRACK || m_st == S_LOCKED) begin
            e_kp = int'(kp_user); e_ki = int'(ki_user);
        end else if (m_st == S_ACQ) begin
            e_kp = 3; e_ki = 3;
        end else begin
            e_kp = 0; e_ki = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_state"}, int'(state_o), m_st);
        check({tag, "_outs"}, int'({kp_sel, ki_sel, int_clear, locked, fault}),
              (e_kp << 5) | (e_ki << 3) | (e_clr << 2) | (e_lock << 1) | e_fault);
        check({tag, "_lol"}, int'(lol_count), m_lol);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic meas(input logic [15:0] e);
        phase_valid = 1'b1;
        phase_err   = e;
        tick();
        phase_valid = 1'b0;
    endtask

    task automatic wait_st(input string tag, input int s, input int max_cyc);
        int n;
        n = 0;
        while (m_st != s && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, int'(state_o), s);
    endtask

    function automatic logic [15:0] rand_err();
        case ($urandom_range(0, 11))
            0:  return 16'd0;
            1:  return 16'd64;
            2:  return 16'(-64);
            3:  return 16'd65;
            4:  return 16'(-65);
            5:  return 16'd1024;
            6:  return 16'd1025;
            7:  return 16'd300;
            8:  return 16'h8000;
            9:  return 16'($urandom_range(0, 65535));
            default: return 16'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        int s2[8];
        model_reset();

        // reset values
        #2 rst = 1'b1;
        #1;
        compare_all("reset");
        check("reset_clear", int'(int_clear), 1);
        idle(2);
        rst = 1'b0;

        // 1: basic acquisition to lock
        start = 1'b1;
        idle(1);
        check("t1_clear", int'(state_o), S_CLEAR);
        idle(7);
        check("t1_clear_end", int'(state_o), S_CLEAR);
        idle(1);
        check("t1_acq_gain", int'({kp_sel, ki_sel}), 4'hF);
        for (int i = 0; i < 100 && m_st != S_LOCKED; i++) begin
            meas(16'd0);
            idle(7);
        end
        check("t1_locked", int'(locked), 1);
        check("t1_user_gain", int'({kp_sel, ki_sel}), 4'b0110);

        // 2: strike run interrupted, then four consecutive strikes
        s2 = '{300, 300, 300, 0, 300, 300, 300, 300};
        for (int i = 0; i < 8; i++) begin
            meas(16'(s2[i]));
            idle(3);
            if (i == 6) check("t2_hold", int'(locked), 1);
        end
        check("t2_unlock", int'(locked), 0);
        check("t2_lol", int'(lol_count), 1);
        check("t2_state", int'(state_o), S_ACQ);

        // 3: acquisition timeout
        start = 1'b0;
        idle(2);
        check("t3_idle", int'(state_o), S_IDLE);
        start = 1'b1;
        wait_st("t3_acq", S_ACQ, 20);
        for (int i = 0; i < ACQ_TIMEOUT - 1; i++) meas(16'd2000);
        check("t3_nofault", int'(fault), 0);
        meas(16'd2000);
        check("t3_fault", int'(fault), 1);
        check("t3_fstate", int'(state_o), S_FAULT);
        idle(3);
        start = 1'b0;
        idle(1);
        check("t3_exit", int'(state_o), S_IDLE);
        check("t3_fclr", int'(fault), 0);

        // 4: saturation and inclusive lock bound
        start = 1'b1;
        wait_st("t4_acq", S_ACQ, 20);
        for (int i = 0; i < LOCK_CNT; i++) meas(16'd0);
        check("t4_track", int'(state_o), S_TRACK);
        meas(16'h8000);
        check("t4_sat", int'(state_o), S_ACQ);
        for (int i = 0; i < LOCK_CNT; i++) meas(16'd0);
        for (int i = 0; i < 8; i++) meas(16'd64);
        meas(16'd65);
        for (int i = 0; i < 8; i++) meas(16'(-64));
        meas(16'(-65));
        for (int i = 0; i < LOCK_CNT - 1; i++) meas((i % 2) ? 16'd64 : 16'(-64));
        check("t4_run15", int'(state_o), S_TRACK);
        meas(16'd64);
        check("t4_lock", int'(state_o), S_LOCKED);

        // 5: ena low freezes everything
        start = 1'b0;
        idle(1);
        start = 1'b1;
        wait_st("t5_acq", S_ACQ, 20);
        for (int i = 0; i < LOCK_CNT; i++) meas(16'd0);
        for (int i = 0; i < 5; i++) meas(16'd0);
        ena = 1'b0;
        for (int i = 0; i < 100; i++) begin
            phase_valid = (i % 3 == 0);
            phase_err   = rand_err();
            tick();
        end
        phase_valid = 1'b0;
        check("t5_frozen", int'(state_o), S_TRACK);
        ena = 1'b1;
        for (int i = 0; i < LOCK_CNT - 6; i++) meas(16'd0);
        check("t5_run_kept", int'(state_o), S_TRACK);
        meas(16'd0);
        check("t5_lock", int'(state_o), S_LOCKED);

        // 6: manual gains and async reset in LOCKED
        auto_en = 1'b0;
        kp_user = 2'b01;
        ki_user = 2'b10;
        start = 1'b0;
        idle(2);
        check("t6_idle_gain", int'({kp_sel, ki_sel}), 4'b0110);
        start = 1'b1;
        wait_st("t6_acq", S_ACQ, 20);
        check("t6_acq_gain", int'({kp_sel, ki_sel}), 4'b0110);
        for (int i = 0; i < 2 * LOCK_CNT; i++) meas(16'd0);
        check("t6_lock", int'(state_o), S_LOCKED);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_state", int'(state_o), S_IDLE);
        check("t6_rst_outs", int'({kp_sel, ki_sel, int_clear, locked, fault}), 4);
        check("t6_rst_lol", int'(lol_count), 0);
        idle(2);
        rst = 1'b0;
        auto_en = 1'b1;

        // random phase
        for (int i = 0; i < 3000; i++) begin
            ena         = ($urandom_range(0, 15) != 0);
            start       = ($urandom_range(0, 127) != 0);
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            kp_user     = 2'($urandom_range(0, 3));
            ki_user     = 2'($urandom_range(0, 3));
            phase_valid = ($urandom_range(0, 1) == 1);
            phase_err   = ($urandom_range(0, 3) == 0) ? rand_err() : 16'($urandom_range(0, 60));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
